// File: rtl/bp_me_io_cmd_arb2_pkg.sv
// Shared types for the two-requester host I/O command arbiter.
// The message struct stands in for the processor's cce_mem_msg layout.
package bp_me_io_cmd_arb2_pkg;

  // Kept as a named width so an N-way arbiter can widen the tag later.
  localparam int arb2_src_id_width_lp = 1;

  typedef struct packed {
    logic [3:0]  msg_type;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [63:0] data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/bp_me_io_cmd_arb2_tag_fifo.sv
// Source-id FIFO recording which requester owns each in-flight command.
// Zero-latency head read; full/empty use an extra pointer wrap bit, so els_p must be a power of 2.
module bp_me_io_cmd_arb2_tag_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 4,
  localparam int aw_lp  = $clog2(els_p)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [width_p-1:0] push_dat,
  input  logic               pop,
  output logic [width_p-1:0] head_dat,
  output logic               full,
  output logic               empty
);

  logic [aw_lp:0]     wr_ptr;
  logic [aw_lp:0]     rd_ptr;
  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (aw_lp+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (aw_lp+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they were written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[aw_lp-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[aw_lp-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[aw_lp] != rd_ptr[aw_lp]) &&
                    (wr_ptr[aw_lp-1:0] == rd_ptr[aw_lp-1:0]);

endmodule

// File: rtl/bp_me_io_cmd_arb2.sv
// Round-robin merge of two command streams onto one host link, zero added latency on cmd_o;
// a stalled grant is locked until it transfers, and responses are steered back in command order.
module bp_me_io_cmd_arb2
  import bp_me_io_cmd_arb2_pkg::*;
#(
  parameter int els_p        = 4,
  parameter bit sticky_err_p = 1'b1,
  localparam int cnt_w_lp    = $clog2(els_p+1)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  bp_cce_mem_msg_s [1:0] src_cmd_i,
  input  logic [1:0]            src_cmd_v_i,
  output logic [1:0]            src_cmd_ready_o,
  output bp_cce_mem_msg_s       cmd_o,
  output logic                  cmd_v_o,
  input  logic                  cmd_ready_i,
  input  bp_cce_mem_msg_s       resp_i,
  input  logic                  resp_v_i,
  output logic                  resp_yumi_o,
  output bp_cce_mem_msg_s [1:0] src_resp_o,
  output logic [1:0]            src_resp_v_o,
  input  logic [1:0]            src_resp_ready_i,
  output logic [cnt_w_lp-1:0]   outstanding_o,
  output logic                  error_o
);

  logic                lock_r;
  logic                sel_r;
  logic                rr_last_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                error_r;

  logic sel;
  logic sel_v;
  logic stall;
  logic push;
  logic pop;
  logic drop;
  logic resp_live;
  logic fifo_full;
  logic fifo_empty;
  logic head;

  always_comb begin
    if (lock_r)              sel = sel_r;
    else if (&src_cmd_v_i)   sel = ~rr_last_r;
    else                     sel = src_cmd_v_i[1];
  end

  // Outputs are qualified by reset so they fall the moment reset asserts, not at the next edge.
  assign sel_v           = src_cmd_v_i[sel] & reset_n_i;
  assign cmd_o           = src_cmd_i[sel];
  assign cmd_v_o         = sel_v & ~fifo_full;
  assign src_cmd_ready_o = {2{cmd_v_o & cmd_ready_i}} & {sel, ~sel};
  assign push            = cmd_v_o & cmd_ready_i;
  assign stall           = cmd_v_o & ~cmd_ready_i;

  assign resp_live    = resp_v_i & reset_n_i;
  assign src_resp_v_o = (resp_live && !fifo_empty) ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign src_resp_o   = {resp_i, resp_i};
  assign pop          = |(src_resp_v_o & src_resp_ready_i);
  // A response with nothing outstanding is swallowed so the link never wedges.
  assign drop         = resp_live & fifo_empty;
  assign resp_yumi_o  = pop | drop;

  bp_me_io_cmd_arb2_tag_fifo #(
    .width_p (arb2_src_id_width_lp),
    .els_p   (els_p)
  ) tag_fifo (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .push     (push),
    .push_dat (sel),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_r    <= 1'b0;
      sel_r     <= 1'b0;
      rr_last_r <= 1'b1;
      cnt_r     <= '0;
      error_r   <= 1'b0;
    end else begin
      lock_r <= stall;
      if (stall) sel_r     <= sel;
      if (push)  rr_last_r <= sel;
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
      error_r <= sticky_err_p ? (error_r | drop) : drop;
    end
  end

  assign outstanding_o = cnt_r;
  assign error_o       = error_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (cnt_r <= cnt_w_lp'(els_p));
  end
`endif

endmodule

// File: tb/tb_bp_me_io_cmd_arb2.sv
// Directed bench for bp_me_io_cmd_arb2 with hand-computed expectations.
module tb_bp_me_io_cmd_arb2;
  import bp_me_io_cmd_arb2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  bp_cce_mem_msg_s [1:0] src_cmd;
  logic [1:0]            src_cmd_v;
  logic [1:0]            src_cmd_ready;
  bp_cce_mem_msg_s       cmd;
  logic                  cmd_v;
  logic                  cmd_ready;
  bp_cce_mem_msg_s       resp;
  logic                  resp_v;
  logic                  resp_yumi;
  bp_cce_mem_msg_s [1:0] src_resp;
  logic [1:0]            src_resp_v;
  logic [1:0]            src_resp_ready;
  logic [2:0]            outstanding;
  logic                  error;

  int total = 0;
  int bad   = 0;

  bp_me_io_cmd_arb2 #(.els_p(4), .sticky_err_p(1'b1)) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .src_cmd_i        (src_cmd),
    .src_cmd_v_i      (src_cmd_v),
    .src_cmd_ready_o  (src_cmd_ready),
    .cmd_o            (cmd),
    .cmd_v_o          (cmd_v),
    .cmd_ready_i      (cmd_ready),
    .resp_i           (resp),
    .resp_v_i         (resp_v),
    .resp_yumi_o      (resp_yumi),
    .src_resp_o       (src_resp),
    .src_resp_v_o     (src_resp_v),
    .src_resp_ready_i (src_resp_ready),
    .outstanding_o    (outstanding),
    .error_o          (error)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s mk(input logic [7:0] id);
    bp_cce_mem_msg_s m;
    m.msg_type = id[3:0];
    m.size     = 3'd3;
    m.addr     = {32'h8000_0000, id};
    m.data     = {8{id}};
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    src_cmd[0]     = '0;
    src_cmd[1]     = '0;
    src_cmd_v      = 2'b00;
    cmd_ready      = 1'b0;
    resp           = '0;
    resp_v         = 1'b0;
    src_resp_ready = 2'b00;
    #12;
    check("rst_out",   outstanding,   0);
    check("rst_err",   error,         0);
    check("rst_cmdv",  cmd_v,         0);
    check("rst_rdy",   src_cmd_ready, 2'b00);
    check("rst_rspv",  src_resp_v,    2'b00);
    check("rst_yumi",  resp_yumi,     0);
    rst_n = 1'b1;
    tick();

    // Single source, back-to-back commands then in-order responses.
    src_cmd_v = 2'b01;
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_cmd[0] = mk(8'hA0 + 8'(i));
      #3;
      check("t1_cmdv", cmd_v, 1);
      check("t1_rdy",  src_cmd_ready, 2'b01);
      check("t1_cmd",  cmd, mk(8'hA0 + 8'(i)));
      tick();
      check("t1_out",  outstanding, i + 1);
    end
    src_cmd_v      = 2'b00;
    resp           = mk(8'hC0);
    resp_v         = 1'b1;
    src_resp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t1_rspv",  src_resp_v, 2'b01);
      check("t1_yumi",  resp_yumi, 1);
      check("t1_rsp1",  src_resp[1], mk(8'hC0));
      tick();
      check("t1_drain", outstanding, 2 - i);
    end
    resp_v = 1'b0;

    // Both sources continuously valid: strict alternation from source 0.
    do_reset();
    src_cmd[0] = mk(8'h10);
    src_cmd[1] = mk(8'h11);
    src_cmd_v  = 2'b11;
    resp       = mk(8'hD0);
    for (int i = 0; i < 8; i++) begin
      resp_v = (i > 0);
      #3;
      check("t2_grant", src_cmd_ready, (i % 2) ? 2'b10 : 2'b01);
      check("t2_cmd",   cmd, mk(8'h10 + 8'(i % 2)));
      if (i > 0) check("t2_steer", src_resp_v, ((i - 1) % 2) ? 2'b10 : 2'b01);
      tick();
      check("t2_out", outstanding, 1);
    end
    src_cmd_v = 2'b00;
    #3;
    check("t2_last", src_resp_v, 2'b10);
    tick();
    check("t2_out0", outstanding, 0);
    resp_v = 1'b0;

    // Stalled grant to source 1 must not be stolen by source 0.
    src_cmd[0] = mk(8'h30);
    src_cmd[1] = mk(8'h31);
    cmd_ready  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      src_cmd_v = (c >= 2) ? 2'b11 : 2'b10;
      #3;
      check("t3_hold", cmd, mk(8'h31));
      check("t3_rdy",  src_cmd_ready, 2'b00);
      check("t3_cmdv", cmd_v, 1);
      tick();
    end
    cmd_ready = 1'b1;
    #3;
    check("t3_first", src_cmd_ready, 2'b10);
    check("t3_cmd1",  cmd, mk(8'h31));
    tick();
    src_cmd_v = 2'b01;
    #3;
    check("t3_second", src_cmd_ready, 2'b01);
    check("t3_cmd0",   cmd, mk(8'h30));
    tick();
    check("t3_out", outstanding, 2);

    // Fill to four, then a pop in the full cycle must not let the pending command through.
    src_cmd[0] = mk(8'h40);
    #3;
    check("t4_rdy", src_cmd_ready, 2'b01);
    tick();
    check("t4_out3", outstanding, 3);
    tick();
    check("t4_out4", outstanding, 4);
    resp   = mk(8'hE0);
    resp_v = 1'b1;
    #3;
    check("t4_fullv",   cmd_v, 0);
    check("t4_fullrdy", src_cmd_ready, 2'b00);
    check("t4_head1",   src_resp_v, 2'b10);
    check("t4_yumi",    resp_yumi, 1);
    tick();
    check("t4_pop", outstanding, 3);
    resp_v = 1'b0;
    #3;
    check("t4_resume", src_cmd_ready, 2'b01);
    tick();
    check("t4_refill", outstanding, 4);
    src_cmd_v = 2'b00;
    resp_v    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("t4_steer0", src_resp_v, 2'b01);
      tick();
      check("t4_drain", outstanding, 3 - i);
    end

    // Response with nothing outstanding is dropped and flagged.
    #3;
    check("t5_yumi",  resp_yumi, 1);
    check("t5_rspv",  src_resp_v, 2'b00);
    check("t5_err0",  error, 0);
    tick();
    check("t5_err1", error, 1);
    resp_v = 1'b0;
    tick();
    tick();
    check("t5_sticky", error, 1);
    check("t5_out",    outstanding, 0);

    // Asynchronous reset with two commands in flight.
    src_cmd[0] = mk(8'h60);
    src_cmd[1] = mk(8'h61);
    src_cmd_v  = 2'b11;
    #3;
    check("t6_g1", src_cmd_ready, 2'b10);
    tick();
    #3;
    check("t6_g0", src_cmd_ready, 2'b01);
    tick();
    check("t6_out2", outstanding, 2);
    cmd_ready      = 1'b0;
    resp_v         = 1'b1;
    src_resp_ready = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_cmdv", cmd_v, 0);
    check("t6_rdy",  src_cmd_ready, 2'b00);
    check("t6_rspv", src_resp_v, 2'b00);
    check("t6_yumi", resp_yumi, 0);
    check("t6_out",  outstanding, 0);
    check("t6_err",  error, 0);
    rst_n = 1'b1;
    #2;
    resp_v    = 1'b0;
    cmd_ready = 1'b1;
    #1;
    check("t6_first", src_cmd_ready, 2'b01);
    check("t6_cmd",   cmd, mk(8'h60));
    tick();
    check("t6_out1", outstanding, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
